// File: rtl/cp_inserter_if.sv
// cp_inserter_if: sample stream bundle for the cyclic-prefix inserter.
// Carries the IFFT-side input stream (s_axis_in_*) and the CP-extended
// output stream (m_axis_out_*). The inserter uses the slave view; whatever
// feeds it and drains it uses the master view.
interface cp_inserter_if #(
    parameter int IN_DW = 32
);
    logic [IN_DW-1:0] s_axis_in_tdata;
    logic             s_axis_in_tvalid;
    logic             s_axis_in_tuser;
    logic             s_axis_in_tready;

    logic [IN_DW-1:0] m_axis_out_tdata;
    logic             m_axis_out_tvalid;
    logic             m_axis_out_tready;
    logic             m_axis_out_tlast;
    logic             m_axis_out_tuser;

    modport slave (
        input  s_axis_in_tdata,
        input  s_axis_in_tvalid,
        input  s_axis_in_tuser,
        output s_axis_in_tready,
        output m_axis_out_tdata,
        output m_axis_out_tvalid,
        input  m_axis_out_tready,
        output m_axis_out_tlast,
        output m_axis_out_tuser
    );

    modport master (
        output s_axis_in_tdata,
        output s_axis_in_tvalid,
        output s_axis_in_tuser,
        input  s_axis_in_tready,
        input  m_axis_out_tdata,
        input  m_axis_out_tvalid,
        output m_axis_out_tready,
        input  m_axis_out_tlast,
        input  m_axis_out_tuser
    );
endinterface

// File: rtl/cp_inserter.sv
// cp_inserter: prepends the last CP_LEN samples of each FFT_LEN-sample OFDM
// symbol in front of it. Two-bank ping-pong buffer: one bank fills while the
// other is replayed as CP followed by body.
// Optional feature: define CP_INSERTER_SYMBOL_CNT_EN to add symbol_cnt_o, a
// 16-bit wrapping count of output symbols (tlast handshakes).
//
// Read FSM states (state | meaning):
//   IDLE | no sample held in the output register for a buffered symbol
//   CP   | output register holds a cyclic-prefix sample
//   BODY | output register holds a body sample
module cp_inserter #(
    parameter int IN_DW   = 32,
    parameter int FFT_LEN = 256,
    parameter int CP_LEN  = 18
) (
    input  logic           clk_i,
    input  logic           reset_i,
    cp_inserter_if.slave   bus
`ifdef CP_INSERTER_SYMBOL_CNT_EN
    ,
    output logic [15:0]    symbol_cnt_o
`endif
);
    localparam int AW = $clog2(FFT_LEN);
    localparam logic [AW-1:0] ADDR_LAST = AW'(FFT_LEN - 1);
    localparam logic [AW-1:0] CP_START  = AW'(FFT_LEN - CP_LEN);

    typedef enum logic [1:0] {IDLE, CP, BODY} state_t;

    state_t           state;
    logic [IN_DW-1:0] mem [2][FFT_LEN];
    logic [1:0]       full;
    logic [1:0]       bank_user;
    logic             wr_bank;
    logic             rd_bank;
    logic             other_bank;
    logic             started;
    logic [AW-1:0]    wr_addr;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    nxt_addr;
    logic [IN_DW-1:0] out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_user;
    logic             in_hs;
    logic             wr_done;
    logic             advance;
    logic             rd_release;

    // started holds input ready low for one cycle after reset is released
    assign bus.s_axis_in_tready = started && !full[wr_bank];
    assign in_hs      = bus.s_axis_in_tvalid && bus.s_axis_in_tready;
    assign wr_done    = in_hs && (wr_addr == ADDR_LAST);
    // output register may load a new sample when empty or being accepted
    assign advance    = !out_valid || bus.m_axis_out_tready;
    assign rd_release = (state == BODY) && advance && (rd_addr == ADDR_LAST);
    assign other_bank = ~rd_bank;
    assign nxt_addr   = rd_addr + 1'b1;

    assign bus.m_axis_out_tdata  = out_data;
    assign bus.m_axis_out_tvalid = out_valid;
    assign bus.m_axis_out_tlast  = out_last;
    assign bus.m_axis_out_tuser  = out_user;

    // sample storage, written in arrival order into the current write bank
    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            mem[wr_bank][wr_addr] <= bus.s_axis_in_tdata;
        end
    end

    // write pointer, per-bank SSB marker and full flags (set by writer, cleared by reader)
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            started   <= 1'b0;
            wr_bank   <= 1'b0;
            wr_addr   <= '0;
            full      <= '0;
            bank_user <= '0;
        end else begin
            started <= 1'b1;
            if (in_hs) begin
                if (wr_addr == '0) begin
                    bank_user[wr_bank] <= bus.s_axis_in_tuser;
                end
                wr_addr <= wr_addr + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            // writer and reader never own the same bank, so set and clear cannot collide
            if (wr_done && !wr_bank) begin
                full[0] <= 1'b1;
            end else if (rd_release && !rd_bank) begin
                full[0] <= 1'b0;
            end
            if (wr_done && wr_bank) begin
                full[1] <= 1'b1;
            end else if (rd_release && rd_bank) begin
                full[1] <= 1'b0;
            end
        end
    end

    // read FSM with registered output stage; everything freezes while stalled
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state     <= IDLE;
            rd_bank   <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_user  <= 1'b0;
        end else if (advance) begin
            case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        state     <= CP;
                        rd_addr   <= CP_START;
                        out_valid <= 1'b1;
                        out_data  <= mem[rd_bank][CP_START];
                        out_user  <= bank_user[rd_bank];
                        out_last  <= 1'b0;
                    end else begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_user  <= 1'b0;
                        out_last  <= 1'b0;
                    end
                end
                CP: begin
                    out_valid <= 1'b1;
                    out_user  <= 1'b0;
                    out_last  <= 1'b0;
                    if (rd_addr == ADDR_LAST) begin
                        state    <= BODY;
                        rd_addr  <= '0;
                        out_data <= mem[rd_bank][0];
                    end else begin
                        rd_addr  <= nxt_addr;
                        out_data <= mem[rd_bank][nxt_addr];
                    end
                end
                BODY: begin
                    if (rd_addr == ADDR_LAST) begin
                        rd_bank <= other_bank;
                        // chain straight into the next symbol when it is already buffered
                        if (full[other_bank]) begin
                            state     <= CP;
                            rd_addr   <= CP_START;
                            out_valid <= 1'b1;
                            out_data  <= mem[other_bank][CP_START];
                            out_user  <= bank_user[other_bank];
                            out_last  <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                            out_user  <= 1'b0;
                            out_last  <= 1'b0;
                        end
                    end else begin
                        rd_addr  <= nxt_addr;
                        out_data <= mem[rd_bank][nxt_addr];
                        out_user <= 1'b0;
                        out_last <= (nxt_addr == ADDR_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CP_INSERTER_SYMBOL_CNT_EN
    // count completed output symbols, wrapping at 16 bits
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            symbol_cnt_o <= '0;
        end else if (out_valid && bus.m_axis_out_tready && out_last) begin
            symbol_cnt_o <= symbol_cnt_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_cp_inserter.sv
// tb_cp_inserter: directed bench for cp_inserter (FFT_LEN=16, CP_LEN=4).
// A queue model expands every accepted input symbol into its expected
// CP+body output sequence; one negedge process checks the DUT against it.
module tb_cp_inserter;
    localparam int DW   = 32;
    localparam int N    = 16;
    localparam int CPL  = 4;
    localparam int SLEN = N + CPL;
    localparam int LOGN = 512;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    cp_inserter_if #(.IN_DW(DW)) bus();
`ifdef CP_INSERTER_SYMBOL_CNT_EN
    logic [15:0] symbol_cnt;
`endif

    cp_inserter #(.IN_DW(DW), .FFT_LEN(N), .CP_LEN(CPL)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .bus     (bus)
`ifdef CP_INSERTER_SYMBOL_CNT_EN
        ,
        .symbol_cnt_o (symbol_cnt)
`endif
    );

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } exp_t;

    exp_t          q[$];
    exp_t          e_cur;
    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc = 0;
    int            n_out = 0;
    int            n_stall = 0;
    int            in_cnt = 0;
    int            last_in_cyc = 0;
    int            first_valid_cyc = -1;
    int            model_cnt = 0;
    bit            saw_in_block = 0;
    logic [DW-1:0] sym_buf [N];
    logic          sym_user = 1'b0;
    logic [DW-1:0] log_d [LOGN];
    logic          log_u [LOGN];
    logic          log_l [LOGN];
    int            log_c [LOGN];
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d = '0;
    logic          prev_u = 1'b0;
    logic          prev_l = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] samp(int s, int i);
        return 32'hC0DE_0000 | (32'(s) << 8) | 32'(i);
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(string name, int waited);
        n_cmp++;
        n_err++;
        $display("FAIL %s: gave up after %0d cycles, expected progress", name, waited);
    endtask

    // model + compare: input symbols -> expected CP+body stream, checked each cycle
    always @(negedge clk) begin
        if (reset_i) begin
            q.delete();
            in_cnt     = 0;
            prev_stall = 1'b0;
            model_cnt  = 0;
        end else begin
            if (bus.s_axis_in_tvalid && bus.s_axis_in_tready) begin
                if (in_cnt == 0) sym_user = bus.s_axis_in_tuser;
                sym_buf[in_cnt] = bus.s_axis_in_tdata;
                in_cnt++;
                last_in_cyc = cyc;
                if (in_cnt == N) begin
                    for (int i = N - CPL; i < N; i++)
                        q.push_back('{d: sym_buf[i], u: (i == N - CPL) && sym_user, l: 1'b0});
                    for (int i = 0; i < N; i++)
                        q.push_back('{d: sym_buf[i], u: 1'b0, l: (i == N - 1)});
                    in_cnt = 0;
                end
            end
            if (bus.s_axis_in_tvalid && !bus.s_axis_in_tready) saw_in_block = 1;
            if (prev_stall) begin
                check("hold_valid", bus.m_axis_out_tvalid, 1'b1);
                check("hold_data", bus.m_axis_out_tdata, prev_d);
                check("hold_user", bus.m_axis_out_tuser, prev_u);
                check("hold_last", bus.m_axis_out_tlast, prev_l);
            end
`ifdef CP_INSERTER_SYMBOL_CNT_EN
            check("symbol_cnt", symbol_cnt, model_cnt);
`endif
            if (bus.m_axis_out_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.m_axis_out_tvalid && bus.m_axis_out_tready) begin
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got %h expected no output", bus.m_axis_out_tdata);
                end else begin
                    e_cur = q.pop_front();
                    check("out_data", bus.m_axis_out_tdata, e_cur.d);
                    check("out_user", bus.m_axis_out_tuser, e_cur.u);
                    check("out_last", bus.m_axis_out_tlast, e_cur.l);
                end
                if (n_out < LOGN) begin
                    log_d[n_out] = bus.m_axis_out_tdata;
                    log_u[n_out] = bus.m_axis_out_tuser;
                    log_l[n_out] = bus.m_axis_out_tlast;
                    log_c[n_out] = cyc;
                end
                n_out++;
                if (bus.m_axis_out_tlast) model_cnt = (model_cnt + 1) % 65536;
            end
            if (bus.m_axis_out_tvalid && !bus.m_axis_out_tready) n_stall++;
            prev_stall = bus.m_axis_out_tvalid && !bus.m_axis_out_tready;
            prev_d     = bus.m_axis_out_tdata;
            prev_u     = bus.m_axis_out_tuser;
            prev_l     = bus.m_axis_out_tlast;
        end
    end

    task automatic send_sample(logic [DW-1:0] d, logic u);
        int n;
        bit hs;
        bus.s_axis_in_tdata  = d;
        bus.s_axis_in_tuser  = u;
        bus.s_axis_in_tvalid = 1'b1;
        n  = 0;
        hs = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.s_axis_in_tready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) timeout("in_accept", n);
    endtask

    // tuser is also raised on sample 5 to show that non-first markers are ignored
    task automatic send_symbol(int s, logic u);
        for (int i = 0; i < N; i++)
            send_sample(samp(s, i), (i == 0) ? u : (i == 5));
    endtask

    task automatic stop_in();
        bus.s_axis_in_tvalid = 1'b0;
        bus.s_axis_in_tuser  = 1'b0;
    endtask

    task automatic wait_outputs(int target, string name);
        int n;
        n = 0;
        while (n_out < target && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_out < target) timeout(name, n);
    endtask

    task automatic check_idle_after_reset(string name);
        check({name, "_valid"}, bus.m_axis_out_tvalid, 1'b0);
        check({name, "_data"}, bus.m_axis_out_tdata, '0);
        check({name, "_last"}, bus.m_axis_out_tlast, 1'b0);
        check({name, "_user"}, bus.m_axis_out_tuser, 1'b0);
        check({name, "_tready"}, bus.s_axis_in_tready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int ucnt;
        bus.s_axis_in_tdata   = '0;
        bus.s_axis_in_tvalid  = 1'b0;
        bus.s_axis_in_tuser   = 1'b0;
        bus.m_axis_out_tready = 1'b1;
        reset_i = 1'b1;

        // reset state and release timing of input ready
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_after_reset("rst");
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("rel1_tready", bus.s_axis_in_tready, 1'b0);
        check("rel1_valid", bus.m_axis_out_tvalid, 1'b0);
        @(negedge clk);
        check("rel2_tready", bus.s_axis_in_tready, 1'b1);
        @(posedge clk);
        #1;

        // single symbol: order, markers, latency
        first_valid_cyc = -1;
        base = n_out;
        send_symbol(0, 1'b1);
        stop_in();
        wait_outputs(base + SLEN, "t1_outputs");
        check("t1_first", log_d[base], 32'hC0DE_000C);
        check("t1_first_user", log_u[base], 1'b1);
        check("t1_body0", log_d[base + 4], 32'hC0DE_0000);
        check("t1_final", log_d[base + 19], 32'hC0DE_000F);
        check("t1_final_last", log_l[base + 19], 1'b1);
        ucnt = 0;
        for (int i = 0; i < SLEN; i++) ucnt += int'(log_u[base + i]);
        check("t1_user_count", ucnt, 1);
        check("t1_latency", first_valid_cyc - last_in_cyc, 2);

        // three symbols back to back
        base = n_out;
        saw_in_block = 0;
        send_symbol(1, 1'b0);
        send_symbol(2, 1'b1);
        send_symbol(3, 1'b0);
        stop_in();
        wait_outputs(base + 3 * SLEN, "t2_outputs");
        check("t2_contiguous", log_c[base + 59] - log_c[base], 59);
        check("t2_in_block", saw_in_block, 1'b1);
        check("t2_sym3_first", log_d[base + 40], 32'hC0DE_030C);

        // downstream stall in the middle of the CP
        base = n_out;
        n_stall = 0;
        send_symbol(4, 1'b1);
        stop_in();
        begin
            int n;
            n = 0;
            while (n_out < base + 2 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n_out < base + 2) timeout("t3_cp_start", n);
        end
        bus.m_axis_out_tready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.m_axis_out_tready = 1'b1;
        wait_outputs(base + SLEN, "t3_outputs");
        repeat (5) @(posedge clk);
        #1;
        check("t3_count", n_out - base, SLEN);
        check("t3_stalls", n_stall, 5);
        check("t3_held_sample", log_d[base + 2], 32'hC0DE_040E);

        // reset in the middle of the body, then a clean symbol
        base = n_out;
        send_symbol(5, 1'b0);
        stop_in();
        wait_outputs(base + CPL + 7, "t4_body7");
        reset_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_idle_after_reset("mid_rst");
        @(posedge clk);
        #1 reset_i = 1'b0;
        @(negedge clk);
        check("t4_rel1_tready", bus.s_axis_in_tready, 1'b0);
        check("t4_rel1_valid", bus.m_axis_out_tvalid, 1'b0);
        @(negedge clk);
        check("t4_rel2_tready", bus.s_axis_in_tready, 1'b1);
        @(posedge clk);
        #1;
        base = n_out;
        send_symbol(6, 1'b1);
        stop_in();
        wait_outputs(base + SLEN, "t4_outputs");
        check("t4_first", log_d[base], 32'hC0DE_060C);
        check("t4_first_user", log_u[base], 1'b1);
        check("t4_body0", log_d[base + 4], 32'hC0DE_0600);
`ifdef CP_INSERTER_SYMBOL_CNT_EN
        @(negedge clk);
        check("t4_symcnt", symbol_cnt, 16'd1);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
